weapon_bank: RTL and testbench
==============================

Name: weapon_bank

Overview:
Multi-channel successor to the single ammo counter and fire-gate logic. It holds N_CH independent weapon channels. Each channel has its own ammo count, a programmable magazine maximum, a timed reload sequence and a post-shot cooldown. Fire, load and max commands arrive on one shared command bus, addressed by channel. The block flags illegal shots with a one-cycle error pulse and a reason code, and sits between the mode selector and the spaceship status display.

Parameters:
N_CH, 2, number of weapon channels (1..8)
CH_W, 3, width of channel select; must satisfy 2**CH_W >= N_CH
AMMO_W, 9, ammo count / fire_rate / max width
CD_W, 4, cooldown length width
RELOAD_CYC, 8, cycles spent in RELOAD before ammo is written (>=1)
ATTACK_MODE, 4'b0010, mode_selector value that permits firing

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
mode_selector  in  4  current ship mode; firing legal only when == ATTACK_MODE
ch_sel  in  CH_W  channel addressed by this cycle's command
fire  in  1  fire request on ch_sel
load  in  1  reload request on ch_sel
load_ammo  in  AMMO_W  ammo quantity for load
set_max  in  1  write magazine max for ch_sel
max_in  in  AMMO_W  new max value
fire_rate  in  AMMO_W  rounds consumed per shot
cooldown  in  CD_W  cycles in COOL after a shot (0 = none)
ammo_out  out  N_CH*AMMO_W  packed ammo counts, channel 0 in LSBs
busy  out  N_CH  per-channel: 1 when in COOL or RELOAD
shot  out  1  one-cycle pulse: shot accepted
shot_ch  out  CH_W  channel of accepted shot (valid with shot)
error  out  1  one-cycle pulse: command rejected
err_code  out  3  reason, valid with error; holds last value otherwise

Behaviour:
- Reset (rst=1 at edge): all ammo=0, all max=all-ones, all channels IDLE, timers=0, shot=0, shot_ch=0, error=0, err_code=0. rst overrides every command.
- Per-channel FSM: IDLE, COOL, RELOAD. Timers for all channels run every cycle regardless of ch_sel.
- Command priority on the addressed channel in one cycle: set_max > load > fire. Only the highest-priority asserted command acts. The lower ones are dropped silently, with no error.
- ch_sel >= N_CH with any command asserted: no state change; error=1, err_code=4.
- set_max (any state): max <= max_in; ammo <= min(ammo, max_in) at the same edge. State and timer are unchanged.
- load:
  - From IDLE or COOL: enter RELOAD, timer <= RELOAD_CYC-1, latch min(load_ammo, max). Ammo is unchanged during RELOAD.
  - When RELOAD timer reaches 0: ammo <= latched value, next state IDLE.
  - load while already in RELOAD: error=1, err_code=3, reload continues.
- fire, evaluated in this order, first match wins:
  - mode_selector != ATTACK_MODE -> error, code 1.
  - state COOL or RELOAD -> error, code 3.
  - fire_rate == 0 -> error, code 5.
  - ammo < fire_rate -> error, code 2. Ammo unchanged; no partial shot, no wrap below 0.
  - Otherwise accept: ammo <= ammo - fire_rate; shot=1, shot_ch=ch_sel on the next cycle. If cooldown>0, enter COOL with timer <= cooldown-1; otherwise stay IDLE.
- COOL: decrement timer each cycle; at 0, next state IDLE. A channel is fireable on the cycle after it leaves COOL. A shot with cooldown=1 therefore blocks exactly one following cycle.
- shot, error and shot_ch are registered: asserted in the cycle after the command edge, for exactly one cycle. shot and error are never both 1.
- ammo_out and busy are direct register outputs with no combinational path from inputs.
- Arithmetic is unsigned, AMMO_W bits; no result may exceed max or go below 0.

Test Plan:
- Reset/defaults: rst=1 for 2 cycles -> ammo_out=0, busy=0, shot=0, error=0; a subsequent set_max ch0 max_in=100 reads back as a clamp on the next load.
- Reload timing: max=100, load ch0 load_ammo=150, RELOAD_CYC=8 -> busy[0]=1 for 8 cycles, ammo0 stays 0, then ammo0=100 and busy[0]=0.
- Accepted shot: ammo1=20, attack mode, fire ch1 fire_rate=3 cooldown=2 -> next cycle shot=1, shot_ch=1, ammo1=17; fire again 1 cycle later -> error, code 3; fire 3 cycles after the first -> accepted, ammo1=14.
- Rejections: mode_selector=4'b0001 with fire -> error code 1; ammo=2 with fire_rate=3 -> code 2, ammo stays 2; fire_rate=0 -> code 5; ch_sel=N_CH -> code 4 and no channel changes.
- Priority/concurrency: set_max+load+fire same cycle on ch0 with ammo0=50, max_in=10 -> ammo0=10, no reload, no shot, no error. Meanwhile ch1's RELOAD timer keeps counting and completes on schedule.
- Reset mid-operation: rst asserted during RELOAD on ch0 and COOL on ch1 -> next cycle both IDLE, ammo=0, busy=0, the pending load value is discarded.

Source files
------------

// File: rtl/weapon_bank.sv
// Multi-channel weapon bank: per-channel ammo, magazine max, timed reload and post-shot cooldown,
// driven by a shared channel-addressed command bus with registered shot/error reporting.
module weapon_bank #(
    parameter int         N_CH        = 2,
    parameter int         CH_W        = 3,
    parameter int         AMMO_W      = 9,
    parameter int         CD_W        = 4,
    parameter int         RELOAD_CYC  = 8,
    parameter logic [3:0] ATTACK_MODE = 4'b0010
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               mode_selector,
    input  logic [CH_W-1:0]          ch_sel,
    input  logic                     fire,
    input  logic                     load,
    input  logic [AMMO_W-1:0]        load_ammo,
    input  logic                     set_max,
    input  logic [AMMO_W-1:0]        max_in,
    input  logic [AMMO_W-1:0]        fire_rate,
    input  logic [CD_W-1:0]          cooldown,
    output logic [N_CH*AMMO_W-1:0]   ammo_out,
    output logic [N_CH-1:0]          busy,
    output logic                     shot,
    output logic [CH_W-1:0]          shot_ch,
    output logic                     error,
    output logic [2:0]               err_code
);

    localparam int RLD_W = $clog2(RELOAD_CYC + 1);
    localparam int TMR_W = (CD_W > RLD_W) ? CD_W : RLD_W;
    localparam logic [TMR_W-1:0] RLD_INIT = TMR_W'(RELOAD_CYC - 1);

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_MODE = 3'd1;
    localparam logic [2:0] ERR_AMMO = 3'd2;
    localparam logic [2:0] ERR_BUSY = 3'd3;
    localparam logic [2:0] ERR_CH   = 3'd4;
    localparam logic [2:0] ERR_RATE = 3'd5;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_COOL = 2'd1, ST_RELOAD = 2'd2} ch_state_e;
    typedef enum logic [1:0] {ACT_NONE = 2'd0, ACT_MAX = 2'd1, ACT_LOAD = 2'd2, ACT_FIRE = 2'd3} act_e;

    function automatic logic [AMMO_W-1:0] min_ammo(input logic [AMMO_W-1:0] a,
                                                   input logic [AMMO_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    ch_state_e           state_r     [N_CH];
    logic [TMR_W-1:0]    timer_r     [N_CH];
    logic [AMMO_W-1:0]   ammo_r      [N_CH];
    logic [AMMO_W-1:0]   max_r       [N_CH];
    logic [AMMO_W-1:0]   pend_r      [N_CH];
    logic [N_CH-1:0]     busy_r;
    logic                shot_r;
    logic [CH_W-1:0]     shot_ch_r;
    logic                error_r;
    logic [2:0]          err_code_r;

    ch_state_e           state_nxt_s [N_CH];
    logic [TMR_W-1:0]    timer_nxt_s [N_CH];
    logic [AMMO_W-1:0]   ammo_nxt_s  [N_CH];
    logic [AMMO_W-1:0]   max_nxt_s   [N_CH];
    logic [AMMO_W-1:0]   pend_nxt_s  [N_CH];

    ch_state_e           sel_state_s;
    logic [AMMO_W-1:0]   sel_ammo_s;
    logic                ch_valid_s;
    act_e                act_s;
    logic                err_s;
    logic [2:0]          code_s;

    // State register: channel state, timers, ammo bookkeeping and the registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                state_r[i] <= ST_IDLE;
                timer_r[i] <= '0;
                ammo_r[i]  <= '0;
                max_r[i]   <= '1;
                pend_r[i]  <= '0;
            end
            busy_r     <= '0;
            shot_r     <= 1'b0;
            shot_ch_r  <= '0;
            error_r    <= 1'b0;
            err_code_r <= ERR_NONE;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_r[i] <= state_nxt_s[i];
                timer_r[i] <= timer_nxt_s[i];
                ammo_r[i]  <= ammo_nxt_s[i];
                max_r[i]   <= max_nxt_s[i];
                pend_r[i]  <= pend_nxt_s[i];
                busy_r[i]  <= (state_nxt_s[i] != ST_IDLE);
            end
            shot_r     <= (act_s == ACT_FIRE);
            shot_ch_r  <= (act_s == ACT_FIRE) ? ch_sel : shot_ch_r;
            error_r    <= err_s;
            err_code_r <= err_s ? code_s : err_code_r;
        end
    end

    // Command decode: pick the single winning action on the addressed channel or a reject reason.
    always_comb begin
        sel_state_s = ST_IDLE;
        sel_ammo_s  = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel_state_s = (ch_sel == CH_W'(i)) ? state_r[i] : sel_state_s;
            sel_ammo_s  = (ch_sel == CH_W'(i)) ? ammo_r[i]  : sel_ammo_s;
        end
        ch_valid_s = (32'(ch_sel) < 32'(N_CH));
        act_s      = ACT_NONE;
        err_s      = 1'b0;
        code_s     = ERR_NONE;
        if (!(fire || load || set_max)) begin
            act_s = ACT_NONE;
        end else if (!ch_valid_s) begin
            err_s  = 1'b1;
            code_s = ERR_CH;
        end else if (set_max) begin
            act_s = ACT_MAX;
        end else if (load) begin
            if (sel_state_s == ST_RELOAD) begin
                err_s  = 1'b1;
                code_s = ERR_BUSY;
            end else begin
                act_s = ACT_LOAD;
            end
        end else if (mode_selector != ATTACK_MODE) begin
            err_s  = 1'b1;
            code_s = ERR_MODE;
        end else if (sel_state_s != ST_IDLE) begin
            err_s  = 1'b1;
            code_s = ERR_BUSY;
        end else if (fire_rate == '0) begin
            err_s  = 1'b1;
            code_s = ERR_RATE;
        end else if (sel_ammo_s < fire_rate) begin
            err_s  = 1'b1;
            code_s = ERR_AMMO;
        end else begin
            act_s = ACT_FIRE;
        end
    end

    // Next-state: every channel's timer advances first, then the addressed channel's action overrides.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_nxt_s[i] = state_r[i];
            timer_nxt_s[i] = timer_r[i];
            ammo_nxt_s[i]  = ammo_r[i];
            max_nxt_s[i]   = max_r[i];
            pend_nxt_s[i]  = pend_r[i];
            case (state_r[i])
                ST_COOL, ST_RELOAD: begin
                    if (timer_r[i] == '0) begin
                        state_nxt_s[i] = ST_IDLE;
                        ammo_nxt_s[i]  = (state_r[i] == ST_RELOAD) ? pend_r[i] : ammo_r[i];
                    end else begin
                        timer_nxt_s[i] = timer_r[i] - TMR_W'(1);
                    end
                end
                default: ;
            endcase
            case ((ch_sel == CH_W'(i)) ? act_s : ACT_NONE)
                ACT_MAX: begin
                    // A shrinking magazine also clamps any reload still in flight.
                    max_nxt_s[i]  = max_in;
                    ammo_nxt_s[i] = min_ammo(ammo_nxt_s[i], max_in);
                    pend_nxt_s[i] = min_ammo(pend_r[i], max_in);
                end
                ACT_LOAD: begin
                    state_nxt_s[i] = ST_RELOAD;
                    timer_nxt_s[i] = RLD_INIT;
                    pend_nxt_s[i]  = min_ammo(load_ammo, max_r[i]);
                end
                ACT_FIRE: begin
                    ammo_nxt_s[i] = ammo_r[i] - fire_rate;
                    if (cooldown != '0) begin
                        state_nxt_s[i] = ST_COOL;
                        timer_nxt_s[i] = TMR_W'(cooldown - CD_W'(1));
                    end else begin
                        state_nxt_s[i] = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ammo
        assign ammo_out[g*AMMO_W +: AMMO_W] = ammo_r[g];
    end

    assign busy     = busy_r;
    assign shot     = shot_r;
    assign shot_ch  = shot_ch_r;
    assign error    = error_r;
    assign err_code = err_code_r;

endmodule

// File: tb/tb_weapon_bank.sv
// Randomized + directed bench for weapon_bank: a behavioural model predicts responses into a
// scoreboard queue that an independent monitor drains whenever the DUT reports shot or error.
module tb_weapon_bank;
    localparam int         N_CH       = 2;
    localparam int         CH_W       = 3;
    localparam int         AMMO_W     = 9;
    localparam int         CD_W       = 4;
    localparam int         RELOAD_CYC = 8;
    localparam logic [3:0] ATK        = 4'b0010;
    localparam int         AMAX       = (1 << AMMO_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [3:0]             mode_selector;
    logic [CH_W-1:0]        ch_sel;
    logic                   fire, load, set_max;
    logic [AMMO_W-1:0]      load_ammo, max_in, fire_rate;
    logic [CD_W-1:0]        cooldown;
    logic [N_CH*AMMO_W-1:0] ammo_out;
    logic [N_CH-1:0]        busy;
    logic                   shot, error;
    logic [CH_W-1:0]        shot_ch;
    logic [2:0]             err_code;

    weapon_bank #(.N_CH(N_CH), .CH_W(CH_W), .AMMO_W(AMMO_W), .CD_W(CD_W),
                  .RELOAD_CYC(RELOAD_CYC), .ATTACK_MODE(ATK)) dut (
        .clk(clk), .rst(rst), .mode_selector(mode_selector), .ch_sel(ch_sel),
        .fire(fire), .load(load), .load_ammo(load_ammo), .set_max(set_max),
        .max_in(max_in), .fire_rate(fire_rate), .cooldown(cooldown),
        .ammo_out(ammo_out), .busy(busy), .shot(shot), .shot_ch(shot_ch),
        .error(error), .err_code(err_code));

    always #5 clk = ~clk;

    typedef struct { bit is_shot; int ch; int code; } resp_t;
    resp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 cooling, 2 reloading; left = busy cycles still to go.
    int m_ammo[N_CH], m_max[N_CH], m_pend[N_CH], m_phase[N_CH], m_left[N_CH];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_resp(input bit s, input int ch, input int code);
        resp_t r;
        r.is_shot = s; r.ch = ch; r.code = code;
        exp_q.push_back(r);
    endfunction

    // Applies one clock edge's worth of the rules to the model, using the currently driven inputs.
    function automatic void model_step();
        int c = int'(ch_sel);
        int act = 0;   // 0 none, 1 max, 2 load, 3 fire
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                m_ammo[i] = 0; m_max[i] = AMAX; m_pend[i] = 0; m_phase[i] = 0; m_left[i] = 0;
            end
            return;
        end
        if (fire || load || set_max) begin
            if (c >= N_CH)                      push_resp(1'b0, 0, 4);
            else if (set_max)                   act = 1;
            else if (load && m_phase[c] == 2)   push_resp(1'b0, 0, 3);
            else if (load)                      act = 2;
            else if (mode_selector != ATK)      push_resp(1'b0, 0, 1);
            else if (m_phase[c] != 0)           push_resp(1'b0, 0, 3);
            else if (fire_rate == 0)            push_resp(1'b0, 0, 5);
            else if (m_ammo[c] < int'(fire_rate)) push_resp(1'b0, 0, 2);
            else begin
                act = 3;
                push_resp(1'b1, c, 0);
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (m_phase[i] != 0) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    if (m_phase[i] == 2) m_ammo[i] = m_pend[i];
                    m_phase[i] = 0;
                end
            end
        end
        if (act == 1) begin
            m_max[c]  = int'(max_in);
            m_ammo[c] = (m_ammo[c] < m_max[c]) ? m_ammo[c] : m_max[c];
            m_pend[c] = (m_pend[c] < m_max[c]) ? m_pend[c] : m_max[c];
        end else if (act == 2) begin
            m_phase[c] = 2;
            m_left[c]  = RELOAD_CYC;
            m_pend[c]  = (int'(load_ammo) < m_max[c]) ? int'(load_ammo) : m_max[c];
        end else if (act == 3) begin
            m_ammo[c] = m_ammo[c] - int'(fire_rate);
            if (cooldown != 0) begin
                m_phase[c] = 1;
                m_left[c]  = int'(cooldown);
            end
        end
    endfunction

    task automatic cycle(input bit r, input logic [3:0] mode, input int ch, input bit f,
                         input bit l, input int la, input bit sm, input int mi,
                         input int fr, input int cd);
        int exp_busy = 0;
        rst = r; mode_selector = mode; ch_sel = CH_W'(ch);
        fire = f; load = l; load_ammo = AMMO_W'(la);
        set_max = sm; max_in = AMMO_W'(mi); fire_rate = AMMO_W'(fr); cooldown = CD_W'(cd);
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N_CH; i++) begin
            chk($sformatf("ammo%0d", i), int'(ammo_out[i*AMMO_W +: AMMO_W]), m_ammo[i]);
            if (m_phase[i] != 0) exp_busy |= (1 << i);
        end
        chk("busy", int'(busy), exp_busy);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, ATK, 0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0);
    endtask

    function automatic int ammo_of(input int ch);
        return int'(ammo_out[ch*AMMO_W +: AMMO_W]);
    endfunction

    // Monitor: every reported response must match the oldest predicted one.
    always @(posedge clk) begin
        resp_t e;
        #1;
        if (shot === 1'b1 && error === 1'b1) chk("shot_and_error", 1, 0);
        if (shot === 1'b1 || error === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", int'({shot, error}), 0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_is_shot", int'(shot), int'(e.is_shot));
                if (e.is_shot) chk("shot_ch", int'(shot_ch), e.ch);
                else           chk("err_code", int'(err_code), e.code);
            end
        end
    end

    initial begin
        cycle(1'b1, ATK, 0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0);
        cycle(1'b1, ATK, 0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0);
        chk("rst_shot", int'(shot), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_err_code", int'(err_code), 0);
        chk("rst_ammo", int'(ammo_out), 0);

        // Max clamp on load, then the 8-cycle reload window.
        cycle(1'b0, ATK, 0, 1'b0, 1'b0, 0, 1'b1, 100, 0, 0);
        cycle(1'b0, ATK, 0, 1'b0, 1'b1, 150, 1'b0, 0, 0, 0);
        idle(7);
        chk("reload_busy", int'(busy[0]), 1);
        chk("reload_hold", ammo_of(0), 0);
        idle(1);
        chk("reload_done", ammo_of(0), 100);
        chk("reload_idle", int'(busy[0]), 0);

        // Shot with cooldown 2 on channel 1.
        cycle(1'b0, ATK, 1, 1'b0, 1'b1, 20, 1'b0, 0, 0, 0);
        idle(8);
        cycle(1'b0, ATK, 1, 1'b1, 1'b0, 0, 1'b0, 0, 3, 2);
        chk("shot1", int'(shot), 1);
        chk("shot1_ch", int'(shot_ch), 1);
        chk("shot1_ammo", ammo_of(1), 17);
        cycle(1'b0, ATK, 1, 1'b1, 1'b0, 0, 1'b0, 0, 3, 2);
        chk("cool_err", int'(error), 1);
        chk("cool_code", int'(err_code), 3);
        idle(1);
        cycle(1'b0, ATK, 1, 1'b1, 1'b0, 0, 1'b0, 0, 3, 2);
        chk("shot2", int'(shot), 1);
        chk("shot2_ammo", ammo_of(1), 14);
        idle(3);

        // Rejections.
        cycle(1'b0, 4'b0001, 0, 1'b1, 1'b0, 0, 1'b0, 0, 3, 0);
        chk("mode_code", int'(err_code), 1);
        cycle(1'b0, ATK, 0, 1'b0, 1'b1, 2, 1'b0, 0, 0, 0);
        idle(8);
        cycle(1'b0, ATK, 0, 1'b1, 1'b0, 0, 1'b0, 0, 3, 0);
        chk("low_ammo_code", int'(err_code), 2);
        chk("low_ammo_hold", ammo_of(0), 2);
        cycle(1'b0, ATK, 0, 1'b1, 1'b0, 0, 1'b0, 0, 0, 0);
        chk("rate0_code", int'(err_code), 5);
        cycle(1'b0, ATK, N_CH, 1'b1, 1'b0, 0, 1'b1, 0, 1, 0);
        chk("bad_ch_code", int'(err_code), 4);

        // Priority on ch0 while ch1 reloads.
        cycle(1'b0, ATK, 0, 1'b0, 1'b1, 50, 1'b0, 0, 0, 0);
        idle(8);
        cycle(1'b0, ATK, 1, 1'b0, 1'b1, 30, 1'b0, 0, 0, 0);
        cycle(1'b0, ATK, 0, 1'b1, 1'b1, 200, 1'b1, 10, 3, 1);
        chk("prio_ammo", ammo_of(0), 10);
        chk("prio_no_shot", int'(shot), 0);
        chk("prio_no_err", int'(error), 0);
        idle(6);
        chk("ch1_still_busy", int'(busy[1]), 1);
        idle(1);
        chk("ch1_reloaded", ammo_of(1), 30);

        // Reset in the middle of a reload and a cooldown.
        cycle(1'b0, ATK, 0, 1'b0, 1'b1, 5, 1'b0, 0, 0, 0);
        cycle(1'b0, ATK, 1, 1'b1, 1'b0, 0, 1'b0, 0, 1, 9);
        cycle(1'b1, ATK, 0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0);
        chk("mid_rst_busy", int'(busy), 0);
        idle(10);
        chk("mid_rst_discard", ammo_of(0), 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            int ch = ($urandom_range(0, 9) == 0) ? int'($urandom_range(N_CH, 7))
                                                  : int'($urandom_range(0, N_CH - 1));
            logic [3:0] mode = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ATK;
            cycle(($urandom_range(0, 99) == 0), mode, ch,
                  ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 12),
                  int'($urandom_range(0, AMAX)), ($urandom_range(0, 99) < 6),
                  int'($urandom_range(0, AMAX)), int'($urandom_range(0, 8)),
                  int'($urandom_range(0, 3)));
        end
        idle(2);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
